tdm_demux: RTL and testbench

- Receive end of the lab's time-division multiplexed serial link.
- The transmit end selects one channel bit per clock onto a single line. This block takes that line back apart into CHANNELS parallel channel words of WIDTH bits each.
- Completed frames are registered and drive LEDR/HEX display logic in the top level.

---
 rtl/tdm_demux.sv | 148 ++++++++++++++
 tb/tb_tdm_demux.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// tdm_demux: receive end of the TDM serial link.
// Rebuilds CHANNELS words of WIDTH bits from a serial bit stream.
// Channel 0 arrives first, and each channel is sent MSB first.
// Optional macro TDM_PARITY_CHECK_EN appends an even-parity bit to each frame
// and adds the parity_err output.
//
// state | meaning
// IDLE  | waiting for an accepted bit with frame_start=1
// RECV  | frame partly received; cnt holds the number of bits taken so far
module tdm_demux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 4
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         din,
    input  logic                         din_valid,
    input  logic                         frame_start,
    output logic [CHANNELS*WIDTH-1:0]    ch_data,
    output logic                         frame_valid,
    output logic                         busy,
`ifdef TDM_PARITY_CHECK_EN
    output logic                         parity_err,
`endif
    output logic                         sync_err
);

    localparam int N = CHANNELS * WIDTH;
`ifdef TDM_PARITY_CHECK_EN
    // The parity bit sits at index N, so the counter must be able to reach N.
    localparam int LAST = N;
    localparam int CW   = $clog2(N + 2);
`else
    localparam int LAST = N - 1;
    localparam int CW   = $clog2(N + 1);
`endif
    localparam logic [CW-1:0] LAST_IDX = CW'(LAST);

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [N-1:0]    sr, sr_d;
    logic [N-1:0]    frame_word;
    logic            frame_done;
    logic            resync;
`ifdef TDM_PARITY_CHECK_EN
    logic            par, par_d;
    logic            perr;
`endif

    // State, bit counter and shift register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
`ifdef TDM_PARITY_CHECK_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            sr    <= sr_d;
`ifdef TDM_PARITY_CHECK_EN
            par   <= par_d;
`endif
        end
    end

    // Next-state logic: shift accepted bits, detect frame end and resync.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        sr_d       = sr;
        frame_done = 1'b0;
        resync     = 1'b0;
`ifdef TDM_PARITY_CHECK_EN
        par_d      = par;
        perr       = 1'b0;
`endif
        if (din_valid) begin
            if (frame_start) begin
                // A frame_start always begins a new frame. Inside RECV it also
                // discards the partial frame, even if this would have been
                // the final bit.
                resync  = (state == RECV);
                sr_d    = {sr[N-2:0], din};
                cnt_d   = CW'(1);
                state_d = RECV;
`ifdef TDM_PARITY_CHECK_EN
                par_d   = din;
`endif
            end else if (state == RECV) begin
                if (cnt == LAST_IDX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef TDM_PARITY_CHECK_EN
                    // The parity bit is only checked. It is never shifted into
                    // the data register.
                    if ((par ^ din) == 1'b0) frame_done = 1'b1;
                    else                     perr       = 1'b1;
`else
                    sr_d       = {sr[N-2:0], din};
                    frame_done = 1'b1;
`endif
                end else begin
                    sr_d  = {sr[N-2:0], din};
                    cnt_d = cnt + 1'b1;
`ifdef TDM_PARITY_CHECK_EN
                    par_d = par ^ din;
`endif
                end
            end
        end
    end

    // Reorder the arrival-order shift register into channel slots.
    // The first channel received lands in the lowest slot.
    always_comb begin
        frame_word = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            frame_word[k*WIDTH +: WIDTH] = sr_d[N-1-k*WIDTH -: WIDTH];
        end
    end

    // Registered outputs: frame capture and one-cycle status pulses.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            ch_data     <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_PARITY_CHECK_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            if (frame_done) ch_data <= frame_word;
            frame_valid <= frame_done;
            sync_err    <= resync;
`ifdef TDM_PARITY_CHECK_EN
            parity_err  <= perr;
`endif
        end
    end

    assign busy = (state == RECV);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux with CHANNELS=4 and WIDTH=4.
module tb_tdm_demux;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic [15:0] ch_data;
    logic        frame_valid;
    logic        busy;
    logic        sync_err;
`ifdef TDM_PARITY_CHECK_EN
    logic        parity_err;
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fv_cnt = 0;
    int se_cnt = 0;
    int pe_cnt = 0;
    int c0;
    int c1;

    tdm_demux #(.CHANNELS(4), .WIDTH(4)) dut (
        .clock(clock),
        .resetn(resetn),
        .din(din),
        .din_valid(din_valid),
        .frame_start(frame_start),
        .ch_data(ch_data),
        .frame_valid(frame_valid),
        .busy(busy),
`ifdef TDM_PARITY_CHECK_EN
        .parity_err(parity_err),
`endif
        .sync_err(sync_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_valid) fv_cnt++;
        if (sync_err) se_cnt++;
`ifdef TDM_PARITY_CHECK_EN
        if (parity_err) pe_cnt++;
`endif
        if (frame_valid && sync_err) begin
            checks++;
            errors++;
            $error("FAIL excl: frame_valid and sync_err both 1, required not both");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic b, input logic v, input logic fs);
        din = b;
        din_valid = v;
        frame_start = fs;
        @(posedge clock);
        #1;
        cyc++;
        din_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    // Sends all 16 data bits MSB first, plus an even-parity bit in parity builds.
    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) step(w[i], 1'b1, i == 15);
`ifdef TDM_PARITY_CHECK_EN
        step(^w, 1'b1, 1'b0);
`endif
    endtask

    initial begin
        // Reset state.
        resetn = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("rst_ch_data", 32'(ch_data), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_se", 32'(sync_err), 32'h0);
        resetn = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        chk("idle_ignore_busy", 32'(busy), 32'h0);

        // Contiguous frame 0xA5C3.
        c0 = cyc;
        step(1'b1, 1'b1, 1'b1);
        chk("t1_busy_first", 32'(busy), 32'h1);
        for (int i = 14; i >= 0; i--) begin
            step(logic'((16'hA5C3 >> i) & 1), 1'b1, 1'b0);
            if (i == 1) chk("t1_no_early_fv", 32'(frame_valid), 32'h0);
        end
`ifdef TDM_PARITY_CHECK_EN
        step(1'b0, 1'b1, 1'b0);
`endif
        chk("t1_fv", 32'(frame_valid), 32'h1);
        chk("t1_ch_data", 32'(ch_data), 32'h3C5A);
        chk("t1_busy_done", 32'(busy), 32'h0);
        chk("t1_latency", 32'(cyc - c0), 32'(NB));
        step(1'b0, 1'b0, 1'b0);
        chk("t1_fv_one_cycle", 32'(frame_valid), 32'h0);
        chk("t1_ch_hold", 32'(ch_data), 32'h3C5A);

        // Same frame with gaps: 3 idle cycles after bit 5, 2 after bit 11.
        resetn = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        chk("t2_cleared", 32'(ch_data), 32'h0);
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            step(logic'((16'hA5C3 >> (15 - i)) & 1), 1'b1, i == 0);
            if (i == 5) begin
                for (int g = 0; g < 3; g++) begin
                    step(1'b1, 1'b0, 1'b1);
                    chk("t2_busy_gap1", 32'(busy), 32'h1);
                end
            end
            if (i == 11) begin
                for (int g = 0; g < 2; g++) begin
                    step(1'b0, 1'b0, 1'b0);
                    chk("t2_busy_gap2", 32'(busy), 32'h1);
                end
            end
        end
`ifdef TDM_PARITY_CHECK_EN
        step(1'b0, 1'b1, 1'b0);
`endif
        chk("t2_fv", 32'(frame_valid), 32'h1);
        chk("t2_ch_data", 32'(ch_data), 32'h3C5A);
        chk("t2_latency", 32'(cyc - c0), 32'(NB + 5));
        step(1'b0, 1'b0, 1'b0);

        // 9-bit partial frame, then resync into a full 0xFFFF frame.
        fv_cnt = 0;
        se_cnt = 0;
        step(1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 9; i++) step(logic'(i & 1), 1'b1, 1'b0);
        chk("t3_busy_partial", 32'(busy), 32'h1);
        step(1'b1, 1'b1, 1'b1);
        chk("t3_se_pulse", 32'(sync_err), 32'h1);
        chk("t3_ch_unchanged", 32'(ch_data), 32'h3C5A);
        step(1'b1, 1'b1, 1'b0);
        chk("t3_se_one_cycle", 32'(sync_err), 32'h0);
        for (int i = 2; i < 16; i++) step(1'b1, 1'b1, 1'b0);
`ifdef TDM_PARITY_CHECK_EN
        step(1'b0, 1'b1, 1'b0);
`endif
        chk("t3_fv", 32'(frame_valid), 32'h1);
        chk("t3_ch_data", 32'(ch_data), 32'hFFFF);
        step(1'b0, 1'b0, 1'b0);
        chk("t3_fv_count", 32'(fv_cnt), 32'h1);
        chk("t3_se_count", 32'(se_cnt), 32'h1);

        // Reset in the middle of a frame.
        fv_cnt = 0;
        se_cnt = 0;
        step(1'b1, 1'b1, 1'b1);
        for (int i = 1; i < 8; i++) step(1'b1, 1'b1, 1'b0);
        resetn = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        resetn = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        chk("t4_ch_data", 32'(ch_data), 32'h0);
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_fv_count", 32'(fv_cnt), 32'h0);
        chk("t4_se_count", 32'(se_cnt), 32'h0);

        // Back-to-back frames 0x1234 and 0x8001.
        fv_cnt = 0;
        se_cnt = 0;
        send_word(16'h1234);
        chk("t5_fv_a", 32'(frame_valid), 32'h1);
        chk("t5_ch_a", 32'(ch_data), 32'h4321);
        c1 = cyc;
        send_word(16'h8001);
        chk("t5_fv_b", 32'(frame_valid), 32'h1);
        chk("t5_ch_b", 32'(ch_data), 32'h1008);
        chk("t5_spacing", 32'(cyc - c1), 32'(NB));
        step(1'b0, 1'b0, 1'b0);
        chk("t5_fv_count", 32'(fv_cnt), 32'h2);
        chk("t5_se_count", 32'(se_cnt), 32'h0);

`ifdef TDM_PARITY_CHECK_EN
        // Parity: the first frame has good parity, the second has bad parity.
        pe_cnt = 0;
        fv_cnt = 0;
        step(1'b1, 1'b1, 1'b1);
        for (int i = 14; i >= 0; i--) step(logic'((16'hA5C3 >> i) & 1), 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("p_fv", 32'(frame_valid), 32'h1);
        chk("p_ch_data", 32'(ch_data), 32'h3C5A);
        chk("p_pe_good", 32'(parity_err), 32'h0);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 14; i >= 0; i--) step(logic'((16'h0001 >> i) & 1), 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("p_pe_bad", 32'(parity_err), 32'h1);
        chk("p_fv_bad", 32'(frame_valid), 32'h0);
        chk("p_ch_hold", 32'(ch_data), 32'h3C5A);
        chk("p_busy", 32'(busy), 32'h0);
        step(1'b0, 1'b0, 1'b0);
        chk("p_pe_count", 32'(pe_cnt), 32'h1);
        chk("p_fv_count", 32'(fv_cnt), 32'h1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
